serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 14 +
 rtl/serial_adder_ctrl_adder4.sv | 28 ++
 rtl/serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg
//   Shared definitions for the nibble-serial adder controller: slice width
//   and FSM state encodings (IDLE=0, ADD=1, DONE=2).
package serial_adder_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_adder4.sv
// adder_4
//   4-bit ripple-carry adder, the single arithmetic element of the serial
//   adder. One full-adder cell per bit, carry chained LSB to MSB.
// Ports:
//   x, y : 4-bit addends
//   ci   : carry-in
//   s    : 4-bit sum
//   co   : carry-out of bit 3
module adder_4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Nibble-serial add/subtract unit. Operands are captured on an accepted
//   start, then one 4-bit slice per clock is summed through a single shared
//   adder_4, LSB slice first. Subtraction is a + ~b + 1.
// Parameters:
//   NIBBLES : number of 4-bit slices per operand (W = 4*NIBBLES)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin an operation (sampled in IDLE only)
//   sub, cin     : op select (1 = a-b) and carry-in for add
//   a, b         : W-bit operands
//   result       : W-bit sum/difference, held until next accepted start
//   cout, ovf    : final carry (sub: 1 = no borrow), signed overflow
//   zero         : result == 0
//   busy, done   : not idle, one-cycle result-valid pulse
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic                     cin,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  output logic [SLICE_W*NIBBLES-1:0] result,
  output logic                     cout,
  output logic                     ovf,
  output logic                     zero,
  output logic                     busy,
  output logic                     done
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                carry;
  logic [W-1:0]        a_q, b_q;     // b_q already holds ~b for subtract
  logic [SLICE_W-1:0]  a_nib, b_nib, sum_nib;
  logic                co_nib;
  logic                last;
  logic [W-1:0]        result_nxt;

  // Slice operand mux; the one adder is reused for every nibble.
  assign a_nib = a_q[cnt*SLICE_W +: SLICE_W];
  assign b_nib = b_q[cnt*SLICE_W +: SLICE_W];
  assign last  = (cnt == CW'(NIBBLES-1));

  adder_4 u_add (
    .x  (a_nib),
    .y  (b_nib),
    .ci (carry),
    .s  (sum_nib),
    .co (co_nib)
  );

  // Result as it will look after this slice is written; lets the zero flag
  // settle in the same edge as the final nibble.
  always_comb begin
    result_nxt = result;
    result_nxt[cnt*SLICE_W +: SLICE_W] = sum_nib;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath. The op select is folded into b_q and carry at capture, so
  // nothing downstream needs to know whether this is add or subtract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          cnt   <= '0;
        end
        ADD: begin
          result <= result_nxt;
          carry  <= co_nib;
          cnt    <= cnt + 1'b1;
          if (last) begin
            cout <= co_nib;
            ovf  <= (a_q[W-1] == b_q[W-1]) && (sum_nib[SLICE_W-1] != a_q[W-1]);
            zero <= (result_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, sub, cin;
  logic [W-1:0] a, b, result;
  logic         cout, ovf, zero, busy, done;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   ntot  = 0;
  int   ndone = 0;
  int   d0, first_d, second_d, idle_cnt;

  serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .cin    (cin),
    .a      (a),
    .b      (b),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_done: got result=%0h cout=%0b ovf=%0b zero=%0b want no done",
                 result, cout, ovf, zero);
      end else begin
        e = sb.pop_front();
        chk("result_cout_ovf_zero", 32'({result, cout, ovf, zero}), 32'(e));
      end
    end
  end

  // Issue one operation, scramble inputs while busy, check done latency.
  task automatic issue(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic icin, input logic [W-1:0] er,
                       input logic ec, input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    sb.push_back('{r: er, c: ec, o: eo, z: ez});
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd5);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags",  32'({cout, ovf, zero}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    rst = 1'b0;

    issue("add_7_8",      16'h0007, 16'h0008, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
    issue("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    issue("sub_5_7",      16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    issue("add_cin",      16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0);

    // Second start two cycles into an operation must be dropped.
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; sub = 1'b0; cin = 1'b0; start = 1'b1;
    sb.push_back('{r: 16'h0300, c: 1'b0, o: 1'b0, z: 1'b0});
    d0 = ndone;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("collide_done_count", 32'(ndone - d0), 32'd1);

    issue("sub_8000_1",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Reset during the third ADD cycle: everything clears, no done.
    @(negedge clk);
    a = 16'h4444; b = 16'h4444; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags",  32'({cout, ovf, zero}), 32'd0);
    chk("midrst_busy_done", 32'({busy, done}), 32'd0);
    d0 = ndone;
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", 32'(ndone - d0), 32'd0);
    issue("add_after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

    // start held high for 12 cycles: back-to-back ops every 6 cycles.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    sb.push_back('{r: 16'h0002, c: 1'b0, o: 1'b0, z: 1'b0});
    sb.push_back('{r: 16'h0002, c: 1'b0, o: 1'b0, z: 1'b0});
    first_d = -1; second_d = -1; idle_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        if (first_d < 0) first_d = k;
        else if (second_d < 0) second_d = k;
      end
      if (first_d >= 0 && second_d < 0 && !busy) idle_cnt++;
    end
    start = 1'b0;
    chk("held_first_latency", 32'(first_d), 32'd5);
    chk("held_done_period",   32'(second_d - first_d), 32'd6);
    chk("held_idle_cycles",   32'(idle_cnt), 32'd1);

    repeat (8) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
